// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud divider helper
//
// Purpose: enums for parity mode and receiver state, plus calc_div() which
//          turns clock/baud/oversampling into a tick divider (floor, min 1).
// Ports:   none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } rx_state_e;

  function automatic int calc_div(input int clk, input int baud, input int os);
    int d;
    d = clk / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - oversampling tick generator with restart
//
// Purpose: emits a one-cycle tick every DIV clocks; restart realigns the
//          phase so sampling is referenced to the detected start edge.
// Ports:   clock   in  system clock
//          nreset  in  synchronous active-low reset
//          restart in  zero the divider counter
//          tick    out one-cycle oversampling tick
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic nreset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge clock) begin
    if (!nreset || restart || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable oversampling UART receiver
//
// Purpose: receives DATA_BITS payload frames with optional parity and one or
//          two stop bits, 3-sample majority voting, false-start rejection and
//          a valid/ready output holding register with error flags.
// Ports:   clock, nreset      clock and synchronous active-low reset
//          rx_in              asynchronous serial line, idle high
//          data_out           received payload (LSB first on the line)
//          valid_out/ready_in output handshake
//          parity_err_out     parity mismatch for the held frame
//          frame_err_out      a stop bit sampled 0 for the held frame
//          break_out          held frame was all-zero with a framing error
//          overrun_out        one-cycle pulse when a finished frame is dropped
//          busy_out           receiver not idle
module uart_rx_cfg import uart_pkg::*; #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int BAUDRATE     = 9600,
  parameter int CLK_FREQ     = 50_000_000,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 parity_err_out,
  output logic                 frame_err_out,
  output logic                 break_out,
  output logic                 overrun_out,
  output logic                 busy_out
);

  localparam int DIV = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLING);
  localparam int SW  = $clog2(OVERSAMPLING);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_A    = SW'(OVERSAMPLING / 2 - 1);
  localparam logic [SW-1:0] S_B    = SW'(OVERSAMPLING / 2);
  localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLING / 2 + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam parity_mode_e  PMODE    = parity_mode_e'(PARITY_MODE[1:0]);
  localparam bit            TWO_STOP = (STOP_BITS == 2);

  logic                 r_sync1, r_sync2, r_hist;
  rx_state_e            r_state;
  logic [SW-1:0]        r_s;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_samp_a, r_samp_b;
  logic                 r_perr, r_ferr;

  logic          w_fall, w_restart, w_tick;
  logic [SW-1:0] w_s_next;
  logic          w_maj, w_decide, w_done, w_par_exp, w_ferr_final;

  assign w_fall    = r_hist & ~r_sync2;
  assign w_restart = (r_state == IDLE) & w_fall;
  // s is the position within the bit of the sample being read this tick,
  // so the compare values line up with the nominal sample points.
  assign w_s_next  = (r_s == S_LAST) ? '0 : r_s + 1'b1;
  assign w_maj     = (r_samp_a & r_samp_b) | (r_samp_a & r_sync2) | (r_samp_b & r_sync2);
  assign w_decide  = w_tick & (r_state != IDLE) & (w_s_next == S_DEC);
  // The frame ends at the decision of the last stop bit so a back-to-back
  // start edge half a bit later is still caught in IDLE.
  assign w_done    = w_decide & (((r_state == STOP) & ~TWO_STOP) | (r_state == STOP2));
  assign w_par_exp = (^r_shift) ^ (PMODE == PAR_ODD);
  assign w_ferr_final = r_ferr | ~w_maj;
  assign busy_out  = (r_state != IDLE);

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clock   (clock),
    .nreset  (nreset),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_sync1        <= 1'b1;
      r_sync2        <= 1'b1;
      r_hist         <= 1'b1;
      r_state        <= IDLE;
      r_s            <= '0;
      r_bit_idx      <= '0;
      r_shift        <= '0;
      r_samp_a       <= 1'b0;
      r_samp_b       <= 1'b0;
      r_perr         <= 1'b0;
      r_ferr         <= 1'b0;
      data_out       <= '0;
      valid_out      <= 1'b0;
      parity_err_out <= 1'b0;
      frame_err_out  <= 1'b0;
      break_out      <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      r_sync1     <= rx_in;
      r_sync2     <= r_sync1;
      r_hist      <= r_sync2;
      overrun_out <= 1'b0;

      if (valid_out && ready_in) begin
        valid_out      <= 1'b0;
        parity_err_out <= 1'b0;
        frame_err_out  <= 1'b0;
        break_out      <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state   <= START;
            r_s       <= '0;
            r_bit_idx <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
          end
        end
        default: begin
          if (w_tick) begin
            r_s <= w_s_next;
            if (w_s_next == S_A) r_samp_a <= r_sync2;
            if (w_s_next == S_B) r_samp_b <= r_sync2;
            if (w_decide) begin
              case (r_state)
                START: r_state <= w_maj ? IDLE : DATA;
                DATA: begin
                  r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == B_LAST) begin
                    r_state <= (PMODE != PAR_NONE) ? PARITY : STOP;
                  end
                end
                PARITY: begin
                  r_perr  <= (w_maj != w_par_exp);
                  r_state <= STOP;
                end
                STOP: begin
                  r_ferr  <= ~w_maj;
                  r_state <= TWO_STOP ? STOP2 : IDLE;
                end
                default: r_state <= IDLE;
              endcase
            end
          end
        end
      endcase

      if (w_done) begin
        if (!valid_out || ready_in) begin
          data_out       <= r_shift;
          parity_err_out <= r_perr;
          frame_err_out  <= w_ferr_final;
          break_out      <= (r_shift == '0) & w_ferr_final;
          valid_out      <= 1'b1;
        end else begin
          overrun_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed bench for uart_rx_cfg (8N1, 8E1, 8N2)
module tb_uart_rx_cfg;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       ready_in = 1'b1;
  logic [2:0] rx_line = 3'b111;
  logic [7:0] dout [3];
  logic [2:0] vld, perr, ferr, brk, ovr, busy;

  always #5 clock = ~clock;

  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUDRATE(100_000), .OVERSAMPLING(16),
                .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clock(clock), .nreset(nreset), .rx_in(rx_line[0]), .data_out(dout[0]),
    .valid_out(vld[0]), .ready_in(ready_in), .parity_err_out(perr[0]),
    .frame_err_out(ferr[0]), .break_out(brk[0]), .overrun_out(ovr[0]), .busy_out(busy[0]));

  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUDRATE(100_000), .OVERSAMPLING(16),
                .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .clock(clock), .nreset(nreset), .rx_in(rx_line[1]), .data_out(dout[1]),
    .valid_out(vld[1]), .ready_in(ready_in), .parity_err_out(perr[1]),
    .frame_err_out(ferr[1]), .break_out(brk[1]), .overrun_out(ovr[1]), .busy_out(busy[1]));

  uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUDRATE(100_000), .OVERSAMPLING(16),
                .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
    .clock(clock), .nreset(nreset), .rx_in(rx_line[2]), .data_out(dout[2]),
    .valid_out(vld[2]), .ready_in(ready_in), .parity_err_out(perr[2]),
    .frame_err_out(ferr[2]), .break_out(brk[2]), .overrun_out(ovr[2]), .busy_out(busy[2]));

  int         n_checks = 0;
  int         n_fail = 0;
  int         cap_cnt [3] = '{0, 0, 0};
  int         ovr_cnt [3] = '{0, 0, 0};
  logic [7:0] cap_data [3];
  logic       cap_p [3], cap_f [3], cap_b [3];

  always @(negedge clock) begin
    for (int d = 0; d < 3; d++) begin
      if (vld[d] && ready_in) begin
        cap_cnt[d]++;
        cap_data[d] = dout[d];
        cap_p[d] = perr[d];
        cap_f[d] = ferr[d];
        cap_b[d] = brk[d];
      end
      if (ovr[d]) ovr_cnt[d]++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input int d, input logic [7:0] data, input bit par,
                            input bit st1, input bit st2);
    logic [11:0] fr;
    int n;
    fr = '1;
    n = 0;
    fr[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin fr[n] = data[i]; n++; end
    if (d == 1) begin fr[n] = par; n++; end
    fr[n] = st1; n++;
    if (d == 2) begin fr[n] = st2; n++; end
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1 rx_line[d] = fr[i];
      repeat (15) @(posedge clock);
    end
  endtask

  task automatic line_idle(input int d, input int cyc);
    @(posedge clock); #1 rx_line[d] = 1'b1;
    repeat (cyc) @(posedge clock);
    #1;
  endtask

  task automatic expect_frame(input string name, input int d, input int prev,
                              input logic [7:0] e_data, input bit e_p, input bit e_f, input bit e_b);
    check({name, " count"}, cap_cnt[d] - prev, 1);
    check({name, " data"}, cap_data[d], e_data);
    check({name, " parity_err"}, cap_p[d], e_p);
    check({name, " frame_err"}, cap_f[d], e_f);
    check({name, " break"}, cap_b[d], e_b);
  endtask

  typedef struct {
    int         d;
    logic [7:0] data;
    bit         par, st1, st2;
    logic [7:0] e_data;
    bit         e_p, e_f, e_b;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int prev, lat;

    //           d  data   par st1 st2  e_data e_p e_f e_b
    vecs[0]  = '{0, 8'h5A, 0,  1,  1,  8'h5A, 0,  0,  0};
    vecs[1]  = '{0, 8'h00, 0,  0,  1,  8'h00, 0,  1,  1};
    vecs[2]  = '{0, 8'h3C, 0,  0,  1,  8'h3C, 0,  1,  0};
    vecs[3]  = '{0, 8'hFF, 0,  1,  1,  8'hFF, 0,  0,  0};
    vecs[4]  = '{1, 8'h07, 0,  1,  1,  8'h07, 1,  0,  0};
    vecs[5]  = '{1, 8'h07, 1,  1,  1,  8'h07, 0,  0,  0};
    vecs[6]  = '{1, 8'h00, 0,  1,  1,  8'h00, 0,  0,  0};
    vecs[7]  = '{1, 8'h80, 0,  1,  1,  8'h80, 1,  0,  0};
    vecs[8]  = '{1, 8'h00, 1,  0,  1,  8'h00, 1,  1,  1};
    vecs[9]  = '{2, 8'h3C, 0,  1,  0,  8'h3C, 0,  1,  0};
    vecs[10] = '{2, 8'h00, 0,  0,  0,  8'h00, 0,  1,  1};
    vecs[11] = '{2, 8'hC3, 0,  1,  1,  8'hC3, 0,  0,  0};
    vecs[12] = '{2, 8'h3C, 0,  0,  1,  8'h3C, 0,  1,  0};

    repeat (3) @(posedge clock);
    #1;
    check("reset valid", vld, 3'b000);
    check("reset busy", busy, 3'b000);
    check("reset flags", perr | ferr | brk | ovr, 3'b000);
    check("reset data", dout[0], 8'h00);
    nreset = 1'b1;
    repeat (5) @(posedge clock);

    // 8N1 0xA5: latency from the pin falling edge and single-cycle valid.
    prev = cap_cnt[0];
    lat = 0;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
      begin
        @(posedge clock); #1;
        for (int k = 1; k <= 300; k++) begin
          @(posedge clock); #1;
          if (vld[0]) begin lat = k; break; end
        end
        @(posedge clock); #1;
        check("A5 valid one cycle", vld[0], 1'b0);
      end
    join
    check("A5 latency", lat, 156);
    line_idle(0, 4);
    expect_frame("A5", 0, prev, 8'hA5, 0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      prev = cap_cnt[vecs[i].d];
      send_frame(vecs[i].d, vecs[i].data, vecs[i].par, vecs[i].st1, vecs[i].st2);
      line_idle(vecs[i].d, 20);
      expect_frame($sformatf("vec%0d", i), vecs[i].d, prev,
                   vecs[i].e_data, vecs[i].e_p, vecs[i].e_f, vecs[i].e_b);
    end

    // Overrun: hold ready low across two back-to-back frames.
    ready_in = 1'b0;
    prev = ovr_cnt[0];
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
    line_idle(0, 20);
    check("ovr pulses", ovr_cnt[0] - prev, 1);
    check("ovr valid held", vld[0], 1'b1);
    check("ovr data held", dout[0], 8'h11);
    prev = cap_cnt[0];
    @(posedge clock); #1 ready_in = 1'b1;
    @(posedge clock); #1;
    check("ovr accept valid", vld[0], 1'b0);
    expect_frame("ovr accept", 0, prev, 8'h11, 0, 0, 0);

    // False starts: 4-clock and 1-clock low pulses.
    prev = cap_cnt[0];
    @(posedge clock); #1 rx_line[0] = 1'b0;
    repeat (4) @(posedge clock);
    #1 rx_line[0] = 1'b1;
    @(posedge clock); #1;
    check("glitch busy seen", busy[0], 1'b1);
    repeat (9) @(posedge clock);
    #1;
    check("glitch busy cleared", busy[0], 1'b0);
    @(posedge clock); #1 rx_line[0] = 1'b0;
    @(posedge clock); #1 rx_line[0] = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check("glitch no frame", cap_cnt[0] - prev, 0);
    check("glitch no valid", vld[0], 1'b0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    line_idle(0, 20);
    expect_frame("post glitch", 0, prev, 8'h5A, 0, 0, 0);

    // Reset in the middle of a 0xFF data phase, then a clean 0x81.
    prev = cap_cnt[0];
    fork
      send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1);
      begin
        repeat (60) @(posedge clock);
        #1 nreset = 1'b0;
        @(posedge clock); #1 nreset = 1'b1;
        check("midreset busy", busy[0], 1'b0);
        check("midreset valid", vld[0], 1'b0);
      end
    join
    line_idle(0, 20);
    check("midreset no frame", cap_cnt[0] - prev, 0);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1);
    line_idle(0, 20);
    expect_frame("post reset", 0, prev, 8'h81, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receive path in uart_top. Adds:
- configurable data width, parity mode and stop-bit count
- 3-sample majority voting
- false-start rejection
- parity, framing, break and overrun reporting
- a valid/ready output register

It sits between the rx pad and the UART register/FIFO layer, and is reused by the next uart_top revision.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal 5..9.
- OVERSAMPLING, 16, ticks per bit; even, >=8.
- BAUDRATE, 9600, line bit rate.
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- PARITY_MODE, 0, 0 none / 1 even / 2 odd.
- STOP_BITS, 1, stop bits checked; 1 or 2.

Ports:
- clock  in  1  system clock
- nreset  in  1  reset, synchronous, active-low
- rx_in  in  1  asynchronous serial line, idle high
- data_out  out  DATA_BITS  received payload, LSB first on line
- valid_out  out  1  data_out and status flags hold a frame
- ready_in  in  1  consumer accepts frame when valid_out & ready_in
- parity_err_out  out  1  parity mismatch for held frame
- frame_err_out  out  1  any stop bit sampled 0 for held frame
- break_out  out  1  held frame was all-zero payload with stop bit 0
- overrun_out  out  1  one-cycle pulse: completed frame discarded
- busy_out  out  1  state != IDLE

Behaviour:
- Reset: nreset=0 at posedge clears all state.
  - Outputs all 0. state=IDLE. Synchroniser flops = 1.
  - Applies mid-frame too: the partial frame is dropped and no flags are raised.
- Tick generator:
  - DIV = CLK_FREQ/(BAUDRATE*OVERSAMPLING), integer floor, minimum 1.
  - 1-cycle tick every DIV clocks.
  - Counter restarts at 0 on start detection.
- Input path:
  - 2-flop synchroniser, then 1 history flop.
  - Falling edge = history 1, sync 0.
- Sample counter s runs 0..OVERSAMPLING-1, advancing per tick.
  - Bit value = majority of samples at s = OS/2-1, OS/2 and OS/2+1.
  - Decision is made at s = OS/2+1.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> [STOP2] -> IDLE.
  - IDLE: a falling edge enters START with s=0. Edges in any other state are ignored.
  - START: majority 1 at decision point = false start -> IDLE, no output, no flags. Otherwise continue at s=OS-1.
  - DATA: DATA_BITS bits shifted LSB first. Bit index wraps to PARITY/STOP after DATA_BITS-1.
  - PARITY: present only if PARITY_MODE!=0.
    - Expected bit is XOR of payload for even, inverted for odd.
    - Error latched if the sampled bit differs from expected.
  - STOP: decision sets frame_err if sampled 0.
    - STOP_BITS=2: continue to STOP2 at s=OS-1, check again.
    - The frame completes at the decision point of the last stop bit, not its end, so back-to-back frames resync.
- Completion, in the cycle after the final decision:
  - If valid_out=0, or (valid_out & ready_in) in the same cycle:
    - load data_out and the three flags; valid_out=1.
    - break = payload==0 & frame_err.
  - Otherwise the frame is discarded, overrun_out pulses 1 for one cycle, and held data and flags are unchanged.
- Handshake:
  - valid_out holds until ready_in. Data and flags stay stable while valid.
  - Accept without a new frame: valid_out=0, flags cleared.
- Latency with DIV=1: valid_out rises exactly (N-1)*OS + OS/2 + 4 clocks after the rx_in falling edge at the pin, where N = 1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS.
- Glitch: a single-sample low pulse must not produce a frame.

Decomposition:
- Package uart_pkg holds:
  - parity_mode_e (PAR_NONE, PAR_EVEN, PAR_ODD)
  - rx_state_e (IDLE, START, DATA, PARITY, STOP, STOP2)
  - function calc_div(clk, baud, os)
- Sub-module uart_baud_gen (parameter DIV; ports clock, nreset, restart, tick) is shared with the future TX.

Test Plan:
Common settings: CLK_FREQ=1_600_000, BAUDRATE=100_000, OS=16 (DIV=1). Bit period = 16 clocks.

1. 8N1, send 0xA5 with ready_in=1 -> valid_out rises 156 clocks after the start edge; data_out=0xA5; all flags 0; one-cycle valid.
2. PARITY_MODE=1, send 0x07 with parity bit 0, then 0x07 with correct parity bit 1 -> first frame parity_err_out=1, second frame 0.
3. STOP_BITS=2, send 0x3C with second stop bit 0 -> frame_err_out=1, data_out=0x3C. Then 0x00 with both stop bits 0 -> break_out=1.
4. ready_in=0, send 0x11 then 0x22 back-to-back -> data_out stays 0x11 and overrun_out pulses once. Raise ready_in -> 0x11 accepted, valid_out=0.
5. rx_in low for 4 clocks then high -> no valid_out, busy_out returns 0 by clock 10. A full 0x5A frame follows -> received correctly.
6. nreset=0 for 1 cycle mid-DATA of 0xFF, then a clean 0x81 -> no frame from the aborted one; 0x81 received with no flags.
